// File: rtl/wr_req_tracker_if.sv
// Bus bundle for wr_req_tracker: write-buffer input, CCI-E TX write channel, responses, drain and status.
// The stat_* signals exist only when WR_TRACKER_STATS_EN is defined.
interface wr_req_tracker_if #(
    parameter int ADDR_LMT    = 20,
    parameter int MDATA       = 14,
    parameter int CACHE_WIDTH = 512,
    parameter int MAX_OUTST   = 63
);
    localparam int OUT_W = $clog2(MAX_OUTST + 1);

    logic [ADDR_LMT-1:0]    in_addr;
    logic [MDATA-1:0]       in_mdata;
    logic [CACHE_WIDTH-1:0] in_data;
    logic                   in_en;
    logic                   in_almostfull;

    logic [ADDR_LMT-1:0]    tx_wr_addr;
    logic [MDATA-1:0]       tx_wr_mdata;
    logic [CACHE_WIDTH-1:0] tx_wr_data;
    logic                   tx_wr_en;
    logic                   tx_almostfull;

    logic                   rsp0_valid;
    logic                   rsp1_valid;
    logic                   drain_req;
    logic                   drain_done;
    logic [OUT_W-1:0]       outstanding;
    logic                   err_overflow;
    logic                   err_underflow;
`ifdef WR_TRACKER_STATS_EN
    logic [31:0]            stat_issued;
    logic [31:0]            stat_completed;
`endif

    modport slave (
        input  in_addr, in_mdata, in_data, in_en,
        output in_almostfull,
        output tx_wr_addr, tx_wr_mdata, tx_wr_data, tx_wr_en,
        input  tx_almostfull,
        input  rsp0_valid, rsp1_valid, drain_req,
        output drain_done, outstanding, err_overflow, err_underflow
`ifdef WR_TRACKER_STATS_EN
        , output stat_issued, stat_completed
`endif
    );

    modport master (
        output in_addr, in_mdata, in_data, in_en,
        input  in_almostfull,
        input  tx_wr_addr, tx_wr_mdata, tx_wr_data, tx_wr_en,
        output tx_almostfull,
        output rsp0_valid, rsp1_valid, drain_req,
        input  drain_done, outstanding, err_overflow, err_underflow
`ifdef WR_TRACKER_STATS_EN
        , input stat_issued, stat_completed
`endif
    );
endinterface

// File: rtl/wr_req_tracker.sv
// Write request tracker: queues cache-line writes, issues them under TX and credit limits, counts in-flight writes.
// Optional WR_TRACKER_STATS_EN adds issued/completed statistics counters.
module wr_req_tracker #(
    parameter int ADDR_LMT    = 20,
    parameter int MDATA       = 14,
    parameter int CACHE_WIDTH = 512,
    parameter int FIFO_LOG2   = 3,
    parameter int MAX_OUTST   = 63
) (
    input  logic            clk,
    input  logic            rst,
    wr_req_tracker_if.slave bus
);
    localparam int DEPTH = 2 ** FIFO_LOG2;
    localparam int OUT_W = $clog2(MAX_OUTST + 1);
    localparam int SW    = OUT_W + 2;
    localparam logic [FIFO_LOG2:0] DEPTH_C  = (FIFO_LOG2 + 1)'(DEPTH);
    localparam logic [FIFO_LOG2:0] AF_LVL   = (FIFO_LOG2 + 1)'(DEPTH - 2);
    localparam logic [OUT_W-1:0]   OUT_MAX  = OUT_W'(MAX_OUTST);

    typedef struct packed {
        logic [ADDR_LMT-1:0]    addr;
        logic [MDATA-1:0]       mdata;
        logic [CACHE_WIDTH-1:0] data;
    } line_t;

    typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;

    function automatic logic [OUT_W-1:0] sat_out(input logic signed [SW-1:0] v);
        return (v < 0) ? '0 : v[OUT_W-1:0];
    endfunction

    line_t                mem [DEPTH];
    line_t                in_p0;
    logic                 vld_p0;
    logic [FIFO_LOG2-1:0] wr_ptr, rd_ptr;
    logic [FIFO_LOG2:0]   count;
    logic                 fifo_full, fifo_empty;
    logic                 issue, push_ok, drained;
    logic signed [SW-1:0] out_next;
    state_t               state;

    // Stage p0: capture the write-buffer request
    always_ff @(posedge clk) begin
        in_p0 <= {bus.in_addr, bus.in_mdata, bus.in_data};
        if (rst) vld_p0 <= 1'b0;
        else     vld_p0 <= bus.in_en;
    end

    assign fifo_full  = (count == DEPTH_C);
    assign fifo_empty = (count == '0);
    assign issue      = !fifo_empty && !bus.tx_almostfull && (bus.outstanding < OUT_MAX);
    // A full queue still accepts when the head leaves in the same cycle
    assign push_ok    = vld_p0 && (!fifo_full || issue);
    assign bus.in_almostfull = (count >= AF_LVL);

    // Stage p1: line queue
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= in_p0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            count            <= '0;
            bus.err_overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + FIFO_LOG2'(1);
            if (issue)   rd_ptr <= rd_ptr + FIFO_LOG2'(1);
            case ({push_ok, issue})
                2'b10:   count <= count + (FIFO_LOG2 + 1)'(1);
                2'b01:   count <= count - (FIFO_LOG2 + 1)'(1);
                default: count <= count;
            endcase
            if (vld_p0 && !push_ok) bus.err_overflow <= 1'b1;
        end
    end

    // Stage p2: registered TX write channel
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.tx_wr_en    <= 1'b0;
            bus.tx_wr_addr  <= '0;
            bus.tx_wr_mdata <= '0;
            bus.tx_wr_data  <= '0;
        end else begin
            bus.tx_wr_en <= issue;
            if (issue) {bus.tx_wr_addr, bus.tx_wr_mdata, bus.tx_wr_data} <= mem[rd_ptr];
        end
    end

    assign out_next = $signed({2'b00, bus.outstanding}) + $signed(SW'(issue))
                    - $signed(SW'(bus.rsp0_valid)) - $signed(SW'(bus.rsp1_valid));

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.outstanding   <= '0;
            bus.err_underflow <= 1'b0;
        end else begin
            bus.outstanding <= sat_out(out_next);
            if (out_next < 0) bus.err_underflow <= 1'b1;
        end
    end

    // The staged input counts as queued so a late push extends the drain
    assign drained = fifo_empty && !vld_p0 && (bus.outstanding == '0) && !issue;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            bus.drain_done <= 1'b0;
        end else begin
            bus.drain_done <= 1'b0;
            case (state)
                IDLE:  if (bus.drain_req) state <= DRAIN;
                DRAIN: begin
                    if (!bus.drain_req) begin
                        state <= IDLE;
                    end else if (drained) begin
                        state          <= DONE;
                        bus.drain_done <= 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef WR_TRACKER_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.stat_issued    <= '0;
            bus.stat_completed <= '0;
        end else begin
            bus.stat_issued    <= bus.stat_issued + 32'(issue);
            bus.stat_completed <= bus.stat_completed + 32'(bus.rsp0_valid) + 32'(bus.rsp1_valid);
        end
    end
`endif
endmodule

// File: tb/tb_wr_req_tracker.sv
// Randomized self-checking bench for wr_req_tracker against a queue-based transaction model.
module tb_wr_req_tracker;
    localparam int ADDR_LMT  = 20;
    localparam int MDATA     = 14;
    localparam int CW        = 512;
    localparam int FIFO_LOG2 = 3;
    localparam int MAX_OUTST = 4;
    localparam int DEPTH     = 8;

    typedef struct {
        logic [ADDR_LMT-1:0] addr;
        logic [MDATA-1:0]    mdata;
        logic [CW-1:0]       data;
    } line_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wr_req_tracker_if #(.ADDR_LMT(ADDR_LMT), .MDATA(MDATA), .CACHE_WIDTH(CW), .MAX_OUTST(MAX_OUTST)) bus ();

    wr_req_tracker #(.ADDR_LMT(ADDR_LMT), .MDATA(MDATA), .CACHE_WIDTH(CW),
                     .FIFO_LOG2(FIFO_LOG2), .MAX_OUTST(MAX_OUTST)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Reference model state
    line_t   q[$];
    line_t   stg;
    bit      stg_v;
    int      m_out;
    bit      m_ovf, m_unf, m_en, m_done;
    int      m_fsm;      // 0 idle, 1 draining, 2 done
    line_t   m_tx;
    longint  m_iss, m_cmp;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic line_t rand_line();
        line_t l;
        l.addr  = ADDR_LMT'($urandom);
        l.mdata = MDATA'($urandom);
        for (int k = 0; k < CW / 32; k++) l.data[k*32 +: 32] = $urandom;
        return l;
    endfunction

    task automatic put(input line_t l);
        bus.in_addr  = l.addr;
        bus.in_mdata = l.mdata;
        bus.in_data  = l.data;
    endtask

    task automatic idle();
        bus.in_en = 1'b0; bus.tx_almostfull = 1'b0;
        bus.rsp0_valid = 1'b0; bus.rsp1_valid = 1'b0; bus.drain_req = 1'b0;
        bus.in_addr = '0; bus.in_mdata = '0; bus.in_data = '0;
    endtask

    task automatic model_step();
        bit iss, drained;
        int nxt;
        if (rst) begin
            q.delete(); stg_v = 0; m_out = 0; m_ovf = 0; m_unf = 0; m_en = 0; m_done = 0;
            m_fsm = 0; m_tx.addr = '0; m_tx.mdata = '0; m_tx.data = '0; m_iss = 0; m_cmp = 0;
            return;
        end
        iss     = (q.size() > 0) && !bus.tx_almostfull && (m_out < MAX_OUTST);
        drained = (q.size() == 0) && !stg_v && (m_out == 0) && !iss;
        nxt = m_out + int'(iss) - int'(bus.rsp0_valid) - int'(bus.rsp1_valid);
        if (nxt < 0) begin nxt = 0; m_unf = 1; end
        m_iss += longint'(iss);
        m_cmp += longint'(bus.rsp0_valid) + longint'(bus.rsp1_valid);
        m_en = iss;
        if (iss) m_tx = q.pop_front();
        if (stg_v) begin
            if (q.size() < DEPTH) q.push_back(stg);
            else m_ovf = 1;
        end
        stg_v = bus.in_en;
        stg.addr = bus.in_addr; stg.mdata = bus.in_mdata; stg.data = bus.in_data;
        m_done = 0;
        case (m_fsm)
            0: if (bus.drain_req) m_fsm = 1;
            1: if (!bus.drain_req) m_fsm = 0;
               else if (drained) begin m_fsm = 2; m_done = 1; end
            default: m_fsm = 0;
        endcase
        m_out = nxt;
    endtask

    task automatic compare();
        chk("tx_wr_en", bus.tx_wr_en, m_en);
        chk("tx_wr_addr", bus.tx_wr_addr, m_tx.addr);
        chk("tx_wr_mdata", bus.tx_wr_mdata, m_tx.mdata);
        chk("tx_wr_data", bus.tx_wr_data, m_tx.data);
        chk("outstanding", bus.outstanding, m_out);
        chk("drain_done", bus.drain_done, m_done);
        chk("in_almostfull", bus.in_almostfull, q.size() >= DEPTH - 2);
        chk("err_overflow", bus.err_overflow, m_ovf);
        chk("err_underflow", bus.err_underflow, m_unf);
`ifdef WR_TRACKER_STATS_EN
        chk("stat_issued", bus.stat_issued, m_iss[31:0]);
        chk("stat_completed", bus.stat_completed, m_cmp[31:0]);
`endif
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        compare();
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        cyc(); cyc();
        rst = 1'b0;
    endtask

    line_t t2[9];
    int    n_iss;

    initial begin
        do_reset();
        chk("rst_tx_en", bus.tx_wr_en, 0);
        chk("rst_tx_addr", bus.tx_wr_addr, 0);
        chk("rst_outst", bus.outstanding, 0);
        chk("rst_done", bus.drain_done, 0);
        chk("rst_ovf", bus.err_overflow, 0);
        chk("rst_unf", bus.err_underflow, 0);

        // Single push, 2-cycle latency
        put(rand_line()); bus.in_addr = 20'h00010; bus.in_mdata = 14'd5; bus.in_en = 1'b1;
        cyc(); bus.in_en = 1'b0; cyc(); cyc();
        chk("t1_en", bus.tx_wr_en, 1);
        chk("t1_addr", bus.tx_wr_addr, 20'h00010);
        chk("t1_mdata", bus.tx_wr_mdata, 5);
        chk("t1_outst", bus.outstanding, 1);
        cyc();
        chk("t1_pulse", bus.tx_wr_en, 0);
        bus.rsp0_valid = 1'b1; cyc(); bus.rsp0_valid = 1'b0;
        chk("t1_rsp", bus.outstanding, 0);

        // Overflow with TX stalled, then in-order release
        do_reset();
        bus.tx_almostfull = 1'b1;
        for (int i = 0; i < 9; i++) begin
            t2[i] = rand_line(); put(t2[i]); bus.in_en = 1'b1;
            cyc();
            if (i == 5) chk("t2_af5", bus.in_almostfull, 0);
            if (i == 6) chk("t2_af6", bus.in_almostfull, 1);
        end
        bus.in_en = 1'b0; cyc(); cyc();
        chk("t2_ovf", bus.err_overflow, 1);
        chk("t2_af", bus.in_almostfull, 1);
        bus.tx_almostfull = 1'b0;
        n_iss = 0;
        for (int i = 0; i < 24; i++) begin
            bus.rsp0_valid = (m_out > 0);
            cyc();
            if (bus.tx_wr_en && n_iss < 9) begin
                chk("t2_order", bus.tx_wr_addr, t2[n_iss].addr);
                n_iss++;
            end
        end
        bus.rsp0_valid = 1'b0;
        chk("t2_count", n_iss, 8);

        // Issue plus two responses in one cycle
        do_reset();
        for (int i = 0; i < 3; i++) begin put(rand_line()); bus.in_en = 1'b1; cyc(); end
        bus.in_en = 1'b0; cyc(); cyc(); cyc();
        chk("t3_pre", bus.outstanding, 3);
        put(rand_line()); bus.in_en = 1'b1; cyc(); bus.in_en = 1'b0; cyc();
        bus.rsp0_valid = 1'b1; bus.rsp1_valid = 1'b1; cyc();
        bus.rsp0_valid = 1'b0; bus.rsp1_valid = 1'b0;
        chk("t3_outst", bus.outstanding, 2);
        chk("t3_en", bus.tx_wr_en, 1);

        // Credit limit
        do_reset();
        bus.tx_almostfull = 1'b1;
        for (int i = 0; i < 6; i++) begin put(rand_line()); bus.in_en = 1'b1; cyc(); end
        bus.in_en = 1'b0; cyc(); cyc();
        bus.tx_almostfull = 1'b0;
        n_iss = 0;
        for (int i = 0; i < 10; i++) begin cyc(); if (bus.tx_wr_en) n_iss++; end
        chk("t4_count", n_iss, 4);
        chk("t4_outst", bus.outstanding, 4);
        bus.rsp0_valid = 1'b1; cyc(); bus.rsp0_valid = 1'b0;
        chk("t4_rsp_en", bus.tx_wr_en, 0);
        chk("t4_rsp_out", bus.outstanding, 3);
        cyc();
        chk("t4_fifth", bus.tx_wr_en, 1);
        chk("t4_out4", bus.outstanding, 4);

        // Drain handshake
        do_reset();
        bus.tx_almostfull = 1'b1;
        for (int i = 0; i < 2; i++) begin put(rand_line()); bus.in_en = 1'b1; cyc(); end
        bus.in_en = 1'b0; cyc(); cyc();
        bus.tx_almostfull = 1'b0; bus.drain_req = 1'b1;
        cyc(); cyc(); cyc();
        chk("t5_outst", bus.outstanding, 2);
        bus.rsp0_valid = 1'b1; cyc(); bus.rsp0_valid = 1'b0;
        bus.rsp1_valid = 1'b1; cyc(); bus.rsp1_valid = 1'b0;
        chk("t5_early", bus.drain_done, 0);
        cyc();
        chk("t5_done", bus.drain_done, 1);
        bus.drain_req = 1'b0; cyc();
        chk("t5_pulse", bus.drain_done, 0);
        cyc();

        // Underflow
        do_reset();
        bus.rsp1_valid = 1'b1; cyc(); bus.rsp1_valid = 1'b0;
        chk("t6_outst", bus.outstanding, 0);
        chk("t6_unf", bus.err_underflow, 1);
        cyc(); cyc(); cyc();
        chk("t6_sticky", bus.err_underflow, 1);
        rst = 1'b1; cyc(); rst = 1'b0;
        chk("t6_clear", bus.err_underflow, 0);

        // Randomized traffic including mid-run resets and drain toggling
        idle();
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            put(rand_line());
            bus.in_en = rst ? 1'b0 : (bus.in_almostfull ? ($urandom_range(0, 7) == 0) : 1'($urandom_range(0, 1)));
            bus.tx_almostfull = ($urandom_range(0, 3) == 0);
            bus.rsp0_valid = (m_out > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 60) == 0);
            bus.rsp1_valid = (m_out > 1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 60) == 0);
            if ($urandom_range(0, 15) == 0) bus.drain_req = ~bus.drain_req;
            cyc();
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
